// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: FSM encoding and requester IDs.
package mem_arb_defs;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic REQ_CPU    = 1'b0;
  localparam logic REQ_LOADER = 1'b1;

  // Requester index to one-hot strobe
  function automatic logic [1:0] id2oh(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the one
// that did not own the port last.
module rr_pick
  import mem_arb_defs::*;
(
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       grant_idx
);

  // Winner selection, grant is zero when nobody asks
  always_comb begin
    grant_idx = REQ_CPU;
    if (req_valid == 2'b11)  grant_idx = ~last_grant;
    else if (req_valid[1])   grant_idx = REQ_LOADER;
    grant = (req_valid != 2'b00) ? id2oh(grant_idx) : 2'b00;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single memory port between the CPU controller (0) and the
// program loader (1). One transfer in flight: accept, WAIT_CYCLES of access,
// one response cycle, then back to idle.
module mem_arbiter
  import mem_arb_defs::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int WAIT_CYCLES = 2   // 1..15
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [1:0]    req_valid,
  input  logic [1:0]    req_write,
  input  logic [AW-1:0] req_addr0,
  input  logic [AW-1:0] req_addr1,
  input  logic [DW-1:0] req_wdata0,
  input  logic [DW-1:0] req_wdata1,
  output logic [1:0]    req_ready,
  output logic [1:0]    rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          grant_id
);

  localparam int CW = 4;

  arb_state_e    state;
  logic [CW-1:0] cnt;
  logic          last_grant;
  logic          wr_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic [1:0]    pick_oh;
  logic          pick_id;

  rr_pick u_pick (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .grant      (pick_oh),
    .grant_idx  (pick_id)
  );

  // Acceptance strobe only in IDLE; suppressed while reset is held so a
  // request is never acknowledged and then dropped by the reset.
  always_comb begin
    req_ready = (state == IDLE && !Reset) ? pick_oh : 2'b00;
  end

  // Output decode from the registered state and transfer latches
  always_comb begin
    busy      = (state != IDLE);
    mem_en    = (state == ACCESS);
    mem_we    = (state == ACCESS) && wr_q;
    mem_addr  = (state == ACCESS) ? addr_q  : '0;
    mem_wdata = (state == ACCESS) ? wdata_q : '0;
    rsp_valid = (state == RESP && !Reset) ? id2oh(grant_id) : 2'b00;
    rsp_rdata = (state == RESP && !wr_q)  ? rdata_q : '0;
  end

  // Transfer FSM; reset wins over every transition and aborts in-flight work
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= REQ_LOADER;
      grant_id   <= REQ_CPU;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid != 2'b00) begin
            grant_id <= pick_id;
            wr_q     <= req_write[pick_id];
            addr_q   <= pick_id ? req_addr1  : req_addr0;
            wdata_q  <= pick_id ? req_wdata1 : req_wdata0;
            cnt      <= CW'(WAIT_CYCLES - 1);
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rdata_q <= mem_rdata;
            state   <= RESP;
          end
        end
        RESP: begin
          last_grant <= grant_id;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-timeline model checked every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_mem_arbiter;

  localparam int W = 2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [1:0]  req_valid, req_write;
  logic [31:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
  logic [1:0]  req_ready, rsp_valid;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_en, mem_we, busy, grant_id;

  // Second instance with single-cycle access for back-to-back spacing
  logic [1:0]  d1_valid, d1_ready, d1_rsp;
  logic [31:0] d1_rdata, d1_maddr, d1_mwdata;
  logic        d1_en, d1_we, d1_busy, d1_gid;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  mem_arbiter #(.AW(32), .DW(32), .WAIT_CYCLES(W)) dut (
    .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
  );

  mem_arbiter #(.AW(32), .DW(32), .WAIT_CYCLES(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .req_valid(d1_valid), .req_write(2'b00),
    .req_addr0(32'h100), .req_addr1(32'h0),
    .req_wdata0(32'h0), .req_wdata1(32'h0),
    .req_ready(d1_ready), .rsp_valid(d1_rsp), .rsp_rdata(d1_rdata),
    .mem_en(d1_en), .mem_we(d1_we), .mem_addr(d1_maddr), .mem_wdata(d1_mwdata),
    .mem_rdata(32'hCAFE0001), .busy(d1_busy), .grant_id(d1_gid)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Poll for an acceptance, bounded; returns at the negedge of the accept cycle
  task automatic wait_acc(output logic [1:0] r);
    r = 2'b00;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      r = req_ready;
      if (r != 2'b00) break;
      step();
    end
    if (r == 2'b00) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: no req_ready within 20 cycles");
    end
  endtask

  // Model: each transfer is a timeline anchored at its accept cycle A:
  // access A+1..A+W, response A+W+1, idle again from A+W+2.
  initial begin : model
    int   cyc, acc;
    bit   act, in_acc, in_rsp, idle;
    logic last, gid, wid, mw;
    logic [31:0] ma, mwd, mrd;
    logic [1:0]  e_rdy;
    cyc = 0; acc = 0; act = 0; last = 1'b1; gid = 1'b0; wid = 1'b0;
    mw = 1'b0; ma = '0; mwd = '0; mrd = '0;
    @(posedge Clk);
    forever begin
      @(negedge Clk);
      in_acc = act && (cyc >= acc + 1) && (cyc <= acc + W);
      in_rsp = act && (cyc == acc + W + 1);
      idle   = !in_acc && !in_rsp;
      e_rdy  = 2'b00;
      if (idle && !Reset && req_valid != 2'b00) begin
        if (req_valid == 2'b11) wid = !last;
        else                    wid = req_valid[1];
        e_rdy = wid ? 2'b10 : 2'b01;
      end
      chk("m_req_ready", req_ready, e_rdy);
      chk("m_busy",      busy,      !idle);
      chk("m_grant_id",  grant_id,  gid);
      chk("m_mem_en",    mem_en,    in_acc);
      chk("m_mem_we",    mem_we,    in_acc && mw);
      chk("m_mem_addr",  mem_addr,  in_acc ? ma  : 32'h0);
      chk("m_mem_wdata", mem_wdata, in_acc ? mwd : 32'h0);
      chk("m_rsp_valid", rsp_valid, (in_rsp && !Reset) ? (gid ? 2'b10 : 2'b01) : 2'b00);
      chk("m_rsp_rdata", rsp_rdata, (in_rsp && !mw) ? mrd : 32'h0);
      if (Reset) begin
        act = 0; last = 1'b1; gid = 1'b0;
      end else begin
        if (in_rsp) begin last = gid; act = 0; end
        if (in_acc && cyc == acc + W) mrd = mem_rdata;
        if (e_rdy != 2'b00) begin
          act = 1; acc = cyc; gid = wid; mw = req_write[wid];
          ma  = wid ? req_addr1  : req_addr0;
          mwd = wid ? req_wdata1 : req_wdata0;
        end
      end
      cyc++;
    end
  end

  initial begin : stim
    logic [1:0] r;
    int acc_c[$];
    Reset = 1'b1; req_valid = 2'b00; req_write = 2'b00;
    req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
    mem_rdata = '0; d1_valid = 2'b00;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_gid", grant_id, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 2'b00);

    // CPU load at 0x40, address changed mid-transfer
    step();
    req_valid = 2'b01; req_write = 2'b00; req_addr0 = 32'h40; mem_rdata = 32'hDEADBEEF;
    wait_acc(r);
    chk("cpu_ready", r, 2'b01);
    step(); req_valid = 2'b00; req_addr0 = 32'h80;
    @(negedge Clk);
    chk("cpu_acc1_en", mem_en, 1'b1);
    chk("cpu_acc1_addr", mem_addr, 32'h40);
    step();
    @(negedge Clk);
    chk("cpu_acc2_en", mem_en, 1'b1);
    chk("cpu_acc2_addr", mem_addr, 32'h40);
    step();
    @(negedge Clk);
    chk("cpu_rsp_valid", rsp_valid, 2'b01);
    chk("cpu_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    step();

    // Loader store 0x1234 to 0x10
    req_valid = 2'b10; req_write = 2'b10; req_addr1 = 32'h10; req_wdata1 = 32'h1234;
    wait_acc(r);
    chk("ld_ready", r, 2'b10);
    step(); req_valid = 2'b00;
    @(negedge Clk);
    chk("ld_acc1_we", mem_we, 1'b1);
    chk("ld_acc1_wdata", mem_wdata, 32'h1234);
    step();
    @(negedge Clk);
    chk("ld_acc2_we", mem_we, 1'b1);
    chk("ld_acc2_wdata", mem_wdata, 32'h1234);
    step();
    @(negedge Clk);
    chk("ld_rsp_valid", rsp_valid, 2'b10);
    chk("ld_rsp_rdata", rsp_rdata, 32'h0);
    step();

    // Tie right after reset: CPU, loader, CPU
    Reset = 1'b1; step(); Reset = 1'b0;
    req_valid = 2'b11; req_write = 2'b00;
    wait_acc(r); chk("tie1", r, 2'b01);
    step();
    wait_acc(r); chk("tie2", r, 2'b10);
    step();
    wait_acc(r); chk("tie3", r, 2'b01);
    step(); req_valid = 2'b00;
    repeat (3) step();

    // Reset during the second access cycle of a CPU load
    req_valid = 2'b01;
    wait_acc(r); chk("abort_ready", r, 2'b01);
    step(); req_valid = 2'b00;
    step(); Reset = 1'b1;
    step(); Reset = 1'b0;
    @(negedge Clk);
    chk("abort_rsp", rsp_valid, 2'b00);
    chk("abort_mem_en", mem_en, 1'b0);
    chk("abort_busy", busy, 1'b0);
    step(); req_valid = 2'b11;
    wait_acc(r); chk("abort_tie", r, 2'b01);
    step(); req_valid = 2'b00;
    repeat (3) step();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      req_valid  = 2'($urandom_range(0, 3));
      req_write  = 2'($urandom_range(0, 3));
      req_addr0  = $urandom; req_addr1  = $urandom;
      req_wdata0 = $urandom; req_wdata1 = $urandom;
      mem_rdata  = $urandom;
      step();
    end
    req_valid = 2'b00;
    repeat (4) step();

    // Single-cycle access, request held: accepts every 3 cycles
    d1_valid = 2'b01;
    for (int i = 0; i < 14; i++) begin
      @(negedge Clk);
      if (d1_ready[0]) acc_c.push_back(i);
      step();
    end
    d1_valid = 2'b00;
    if (acc_c.size() < 4) begin
      checks++; errors++;
      $display("FAIL b2b_count: got %0d acceptances expected at least 4", acc_c.size());
    end else begin
      for (int k = 1; k < 4; k++) chk("b2b_gap", 64'(acc_c[k] - acc_c[k-1]), 64'd3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
